// File: rtl/deserializer_pkg.sv
// -----------------------------------------------------------------------------
// deserializer_pkg
//   Shared types and helpers for the deserializer_stream block.
//   - state_t     : assembly FSM states (FILL accepting beats, HOLD waiting
//                   for the output slot to free up).
//   - seg_index() : maps the running beat counter to the physical segment
//                   index, honouring the configured segment order.
//   - calc_cnt_w(): width needed to hold a segment count of 0..num_seg.
// -----------------------------------------------------------------------------
package deserializer_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    // lsb_first=1: beat k goes to segment k (bits [k*IN_W +: IN_W]).
    // lsb_first=0: beat k goes to segment num_seg-1-k (first beat on top).
    function automatic int seg_index(input int ctr, input bit lsb_first, input int num_seg);
        return lsb_first ? ctr : (num_seg - 1 - ctr);
    endfunction

    function automatic int calc_cnt_w(input int num_seg);
        return $clog2(num_seg + 1);
    endfunction

endpackage

// File: rtl/deser_out_slot.sv
// -----------------------------------------------------------------------------
// deser_out_slot
//   One-word output register slice. A load writes data/count/last and raises
//   o_valid; the registered word is held unchanged until the consumer takes it.
//   A take and a load in the same cycle keep o_valid high with the new word.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   i_load              write a new word into the slot this cycle
//   i_data/i_count/
//   i_last              word contents to load
//   i_ready             consumer takes the word when o_valid is high
//   o_valid             slot holds a word
//   o_data/o_count/
//   o_last              registered word contents
// -----------------------------------------------------------------------------
module deser_out_slot #(
    parameter int OUT_W = 512,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic [OUT_W-1:0] i_data,
    input  logic [CNT_W-1:0] i_count,
    input  logic             i_last,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [OUT_W-1:0] o_data,
    output logic [CNT_W-1:0] o_count,
    output logic             o_last
);

    logic             r_valid;
    logic [OUT_W-1:0] r_data;
    logic [CNT_W-1:0] r_count;
    logic             r_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_count <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_count <= i_count;
            r_last  <= i_last;
        end else if (r_valid && i_ready) begin
            // Contents are left in place; only the valid flag drops.
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_count = r_count;
    assign o_last  = r_last;

endmodule

// File: rtl/deserializer_stream.sv
// -----------------------------------------------------------------------------
// deserializer_stream
//   Packs IN_W-bit input beats into OUT_W-bit words. A completed word moves to
//   a one-word output slot so assembly of the next word can proceed while the
//   consumer stalls. in_last closes a partial word early; out_count reports
//   how many segments are valid and unfilled segments read as zero.
//
//   Handshake: a beat moves when in_valid && in_ready; a word moves when
//   out_valid && out_ready. Producers/consumers may assert valid/ready in any
//   order; nothing combinationally depends on the other side's valid except
//   in_ready, which depends only on state and reset.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   in_valid/in_ready   input beat handshake
//   in_data, in_last    input beat and close-word flag
//   out_valid/out_ready output word handshake
//   out_data            assembled word
//   out_count           valid segments in out_data (1..NUM_SEG)
//   out_last            word was closed by in_last
//   dbg_state           current assembly FSM state
// -----------------------------------------------------------------------------
module deserializer_stream
    import deserializer_pkg::*;
#(
    parameter  int IN_W      = 32,
    parameter  int OUT_W     = 512,
    parameter  bit LSB_FIRST = 1'b1,
    localparam int NUM_SEG   = OUT_W / IN_W,
    localparam int SEG_CW    = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1,
    localparam int CNT_W     = calc_cnt_w(NUM_SEG)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_last,
    output state_t           dbg_state
);

    if ((OUT_W % IN_W) != 0 || NUM_SEG < 2) begin : g_param_check
        $error("deserializer_stream: OUT_W must be a multiple of IN_W with at least 2 segments");
    end

    state_t           r_state;
    state_t           w_state_next;
    logic [OUT_W-1:0] r_asm;
    logic [SEG_CW-1:0] r_seg_ctr;
    logic [CNT_W-1:0] r_hold_cnt;
    logic             r_hold_last;

    logic [OUT_W-1:0] w_asm_wr;
    int               w_seg_idx;
    logic             w_accept;
    logic             w_seg_full;
    logic             w_complete;
    logic             w_slot_free;
    logic             w_release;
    logic             w_load;
    logic [OUT_W-1:0] w_load_data;
    logic [CNT_W-1:0] w_load_cnt;
    logic             w_load_last;

    // in_ready is forced low while reset is held, independent of state.
    assign in_ready    = reset_n && (r_state == FILL);
    assign w_accept    = in_valid && in_ready;
    assign w_seg_full  = (r_seg_ctr == SEG_CW'(NUM_SEG - 1));
    assign w_complete  = w_accept && (w_seg_full || in_last);
    assign w_slot_free = !out_valid || out_ready;
    // In HOLD the slot is necessarily occupied; a take frees it for the held word.
    assign w_release   = (r_state == HOLD) && out_valid && out_ready;
    assign w_load      = (w_complete && w_slot_free) || w_release;
    assign w_seg_idx   = seg_index(int'(r_seg_ctr), LSB_FIRST, NUM_SEG);
    assign dbg_state   = r_state;

    // Assembly buffer with the current beat merged into its segment.
    always_comb begin
        w_asm_wr = r_asm;
        w_asm_wr[w_seg_idx*IN_W +: IN_W] = in_data;
    end

    // Slot source: the held word when leaving HOLD, else the word completing now.
    always_comb begin
        w_load_data = w_asm_wr;
        w_load_cnt  = CNT_W'(r_seg_ctr) + CNT_W'(1);
        w_load_last = in_last;
        if (r_state == HOLD) begin
            w_load_data = r_asm;
            w_load_cnt  = r_hold_cnt;
            w_load_last = r_hold_last;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FILL: if (w_complete && !w_slot_free) w_state_next = HOLD;
            HOLD: if (w_release)                  w_state_next = FILL;
            default:                              w_state_next = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_asm       <= '0;
            r_seg_ctr   <= '0;
            r_hold_cnt  <= '0;
            r_hold_last <= 1'b0;
        end else if (w_load) begin
            // Word has moved to the slot; start the next one from segment 0.
            r_asm     <= '0;
            r_seg_ctr <= '0;
        end else if (w_complete) begin
            // Slot busy: park the finished word here until HOLD releases it.
            r_asm       <= w_asm_wr;
            r_hold_cnt  <= CNT_W'(r_seg_ctr) + CNT_W'(1);
            r_hold_last <= in_last;
        end else if (w_accept) begin
            r_asm     <= w_asm_wr;
            r_seg_ctr <= r_seg_ctr + SEG_CW'(1);
        end
    end

    deser_out_slot #(
        .OUT_W (OUT_W),
        .CNT_W (CNT_W)
    ) u_out_slot (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (w_load),
        .i_data  (w_load_data),
        .i_count (w_load_cnt),
        .i_last  (w_load_last),
        .i_ready (out_ready),
        .o_valid (out_valid),
        .o_data  (out_data),
        .o_count (out_count),
        .o_last  (out_last)
    );

endmodule

// File: tb/tb_deserializer_stream.sv
// -----------------------------------------------------------------------------
// tb_deserializer_stream
//   Two instances (LSB-first and MSB-first) share all inputs. A negedge
//   monitor keeps a beat-level reference: beats collect in part_q, and a word
//   is pushed to the expected queues when 4 beats or in_last arrive. Every
//   cycle the outputs are compared with the queue heads; out_valid must equal
//   "a word is owed", and in_ready must be high unless two words are owed.
// -----------------------------------------------------------------------------
module tb_deserializer_stream;
  import deserializer_pkg::*;

  localparam int IN_W  = 8;
  localparam int OUT_W = 32;
  localparam int CNT_W = 3;
  localparam int NSEG  = OUT_W / IN_W;
  localparam int EW    = 1 + CNT_W + OUT_W;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [IN_W-1:0]  in_data = '0;
  logic             in_last = 1'b0;
  logic             out_ready = 1'b1;

  logic             in_ready_a, out_valid_a, out_last_a;
  logic [OUT_W-1:0] out_data_a;
  logic [CNT_W-1:0] out_count_a;
  state_t           dbg_state_a;
  logic             in_ready_b, out_valid_b, out_last_b;
  logic [OUT_W-1:0] out_data_b;
  logic [CNT_W-1:0] out_count_b;
  state_t           dbg_state_b;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [IN_W-1:0] part_q[$];
  logic [EW-1:0]   exp_a_q[$];
  logic [EW-1:0]   exp_b_q[$];

  deserializer_stream #(.IN_W(IN_W), .OUT_W(OUT_W), .LSB_FIRST(1'b1)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_data(out_data_a), .out_count(out_count_a), .out_last(out_last_a),
    .dbg_state(dbg_state_a)
  );

  deserializer_stream #(.IN_W(IN_W), .OUT_W(OUT_W), .LSB_FIRST(1'b0)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_data(out_data_b), .out_count(out_count_b), .out_last(out_last_b),
    .dbg_state(dbg_state_b)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // scoreboard / reference model
  always @(negedge clk) begin
    if (!reset_n) begin
      part_q.delete();
      exp_a_q.delete();
      exp_b_q.delete();
    end else begin
      check("mon_valid_a", 64'(out_valid_a), 64'(exp_a_q.size() != 0));
      check("mon_valid_b", 64'(out_valid_b), 64'(exp_b_q.size() != 0));
      check("mon_ready_a", 64'(in_ready_a), 64'(exp_a_q.size() < 2));
      check("mon_ready_b", 64'(in_ready_b), 64'(exp_b_q.size() < 2));
      if (out_valid_a && exp_a_q.size() != 0)
        check("mon_word_a", 64'({out_last_a, out_count_a, out_data_a}), 64'(exp_a_q[0]));
      if (out_valid_b && exp_b_q.size() != 0)
        check("mon_word_b", 64'({out_last_b, out_count_b, out_data_b}), 64'(exp_b_q[0]));
      if (out_valid_a && out_ready && exp_a_q.size() != 0) void'(exp_a_q.pop_front());
      if (out_valid_b && out_ready && exp_b_q.size() != 0) void'(exp_b_q.pop_front());
      if (in_valid && in_ready_a) begin
        part_q.push_back(in_data);
        if (part_q.size() == NSEG || in_last) begin
          logic [OUT_W-1:0] wa, wb;
          wa = '0;
          wb = '0;
          for (int i = 0; i < part_q.size(); i++) begin
            wa = wa | (OUT_W'(part_q[i]) << (IN_W * i));
            wb = wb | (OUT_W'(part_q[i]) << (IN_W * (NSEG - 1 - i)));
          end
          exp_a_q.push_back({in_last, CNT_W'(part_q.size()), wa});
          exp_b_q.push_back({in_last, CNT_W'(part_q.size()), wb});
          part_q.delete();
        end
      end
    end
  end

  // driver tasks
  task automatic send_beat(input logic [IN_W-1:0] d, input logic last);
    int waited;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    waited   = 0;
    @(negedge clk);
    while (!in_ready_a && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (waited >= 200) check("send_timeout", 64'(waited), 64'(0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_word4(input logic [IN_W-1:0] b0, b1, b2, b3);
    send_beat(b0, 1'b0);
    send_beat(b1, 1'b0);
    send_beat(b2, 1'b0);
    send_beat(b3, 1'b0);
  endtask

  initial begin
    int c0;
    // reset state
    #1;
    check("rst_valid", 64'(out_valid_a), 64'(0));
    check("rst_ready", 64'(in_ready_a), 64'(0));
    check("rst_data",  64'(out_data_a), 64'(0));
    check("rst_count", 64'(out_count_a), 64'(0));
    #11;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // basic full word, both orders, single-cycle valid
    out_ready = 1'b1;
    send_word4(8'h11, 8'h22, 8'h33, 8'h44);
    @(negedge clk);
    check("full_valid", 64'(out_valid_a), 64'(1));
    check("full_data_lsb", 64'(out_data_a), 64'h44332211);
    check("full_data_msb", 64'(out_data_b), 64'h11223344);
    check("full_count", 64'(out_count_a), 64'(4));
    check("full_last", 64'(out_last_a), 64'(0));
    @(negedge clk);
    check("full_single_cycle", 64'(out_valid_a), 64'(0));

    // partial word closed by in_last, then next word starts at segment 0
    @(posedge clk);
    #1;
    send_beat(8'hAA, 1'b0);
    send_beat(8'hBB, 1'b1);
    @(negedge clk);
    check("part_data_lsb", 64'(out_data_a), 64'h0000BBAA);
    check("part_data_msb", 64'(out_data_b), 64'hAABB0000);
    check("part_count", 64'(out_count_a), 64'(2));
    check("part_last", 64'(out_last_a), 64'(1));
    @(posedge clk);
    #1;
    send_word4(8'h11, 8'h22, 8'h33, 8'h44);
    @(negedge clk);
    check("after_part_data", 64'(out_data_a), 64'h44332211);

    // last on first beat, last on final segment
    @(posedge clk);
    #1;
    send_beat(8'h5A, 1'b1);
    @(negedge clk);
    check("first_last_count", 64'(out_count_a), 64'(1));
    check("first_last_data", 64'(out_data_a), 64'h0000005A);
    @(posedge clk);
    #1;
    send_beat(8'h01, 1'b0);
    send_beat(8'h02, 1'b0);
    send_beat(8'h03, 1'b0);
    send_beat(8'h04, 1'b1);
    @(negedge clk);
    check("full_last_count", 64'(out_count_a), 64'(4));
    check("full_last_flag", 64'(out_last_a), 64'(1));

    // stall: two words backed up, in_ready drops, then drain in order
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send_word4(8'h11, 8'h22, 8'h33, 8'h44);
    send_word4(8'h55, 8'h66, 8'h77, 8'h88);
    @(negedge clk);
    check("stall_ready", 64'(in_ready_a), 64'(0));
    check("stall_hold_data", 64'(out_data_a), 64'h44332211);
    repeat (3) @(negedge clk);
    check("stall_stable", 64'(out_data_a), 64'h44332211);
    out_ready = 1'b1;
    @(negedge clk);
    check("drain_valid", 64'(out_valid_a), 64'(1));
    check("drain_data", 64'(out_data_a), 64'h88776655);
    check("drain_ready", 64'(in_ready_a), 64'(1));
    @(negedge clk);
    check("drain_empty", 64'(out_valid_a), 64'(0));

    // back-to-back: 12 beats in 12 cycles
    @(posedge clk);
    #1;
    c0 = cyc;
    for (int i = 0; i < 12; i++) send_beat(IN_W'($urandom_range(0, 255)), 1'b0);
    check("b2b_cycles", 64'(cyc - c0), 64'(12));
    repeat (3) @(negedge clk);

    // reset mid-word while the slot is full
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send_word4(8'hC1, 8'hC2, 8'hC3, 8'hC4);
    send_beat(8'hD1, 1'b0);
    send_beat(8'hD2, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_valid", 64'(out_valid_a), 64'(0));
    check("midrst_ready", 64'(in_ready_a), 64'(0));
    check("midrst_data", 64'(out_data_a), 64'(0));
    check("midrst_last", 64'(out_last_a), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send_word4(8'h01, 8'h02, 8'h03, 8'h04);
    @(negedge clk);
    check("postrst_data", 64'(out_data_a), 64'h04030201);
    check("postrst_count", 64'(out_count_a), 64'(4));

    // randomized traffic checked by the monitor
    @(posedge clk);
    #1;
    for (int i = 0; i < 2000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = IN_W'($urandom_range(0, 255));
      in_last   = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("end_queue_a", 64'(exp_a_q.size()), 64'(0));
    check("end_queue_b", 64'(exp_b_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/deserializer_stream.md
Name: deserializer_stream

Overview:
Parametrised successor to the basic deserializer. It packs IN_W-bit input beats into OUT_W-bit words using valid/ready handshakes on both sides. A one-word output slot lets input assembly continue while the downstream consumer stalls. A last/flush input emits a partial word with a segment count, and segment order within the word is selectable.

Parameters:
IN_W, 32, input beat width in bits
OUT_W, 512, output word width in bits; must be an integer multiple of IN_W
LSB_FIRST, 1, 1: first beat lands in bits [IN_W-1:0]; 0: first beat lands in the top segment
Derived (localparam): NUM_SEG = OUT_W/IN_W, SEG_CW = $clog2(NUM_SEG), CNT_W = $clog2(NUM_SEG+1)

Ports:
clk  input  1  single clock, all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
in_valid  input  1  in_data is valid this cycle
in_ready  output  1  block accepts a beat this cycle
in_data  input  IN_W  input beat
in_last  input  1  with an accepted beat: close the current word after this beat
out_valid  output  1  out_data/out_count/out_last hold a word
out_ready  input  1  consumer takes the word this cycle
out_data  output  OUT_W  assembled word; unfilled segments are zero
out_count  output  CNT_W  number of valid segments, 1..NUM_SEG
out_last  output  1  word was closed by in_last

Behaviour:
- Transfers: an input beat is accepted when in_valid && in_ready; an output word is taken when out_valid && out_ready.
- Reset (reset_n low, asynchronous): the following clear immediately.
  - out_valid=0, out_data=0, out_count=0, out_last=0.
  - Assembly buffer zeroed, seg_ctr=0, state=FILL.
  - in_ready=0 while reset_n is low.
  - Reset mid-word discards the partial word and any word held in the output slot.
- FSM states:
  - FILL: in_ready=1. Each accepted beat is written to segment seg_ctr (LSB_FIRST=0 mirrors the index to NUM_SEG-1-seg_ctr), then seg_ctr increments.
  - A beat completes the word when seg_ctr==NUM_SEG-1 or in_last=1.
  - On a completing beat with slot free (!out_valid || out_ready):
    - next cycle out_data = assembled word including this beat, out_count = seg_ctr+1, out_last = in_last, out_valid=1;
    - assembly buffer cleared, seg_ctr=0, stay in FILL.
  - On a completing beat with slot busy: the word stays in the assembly buffer, count and last are latched, go to HOLD.
  - HOLD: in_ready=0. When out_ready && out_valid, load the slot from assembly next cycle, clear assembly, seg_ctr=0, return to FILL.
- Latency and throughput:
  - Completing beat to out_valid is one cycle.
  - Sustained rate is one beat per cycle with out_ready held high; there are no bubbles at word boundaries.
- Output stability: while out_valid && !out_ready, out_data, out_count and out_last are stable. out_valid drops only after a take with no new word loading.
- Simultaneous events: a take and a slot load in the same cycle keeps out_valid=1 with the new word.
- Boundary cases:
  - in_last on the first beat gives out_count=1.
  - in_last on segment NUM_SEG-1 gives a full word with out_last=1.
  - in_valid while in_ready=0 is ignored; the beat is not consumed.
- Elaboration error (\$error) if OUT_W % IN_W != 0 or NUM_SEG < 2.

Decomposition:
- Package deserializer_pkg:
  - state enum typedef {FILL, HOLD};
  - helper function seg_index(ctr, lsb_first) returning the target segment;
  - shared CNT_W calculation function.
- Sub-module deser_out_slot holds the output register slice: data, count and last registers with the valid/ready hold rule, parametrised by OUT_W and CNT_W.
- The top level holds the assembly buffer, seg_ctr and the FSM.

Test Plan (IN_W=8, OUT_W=32):
- Reset then 4 beats 0x11,0x22,0x33,0x44, out_ready=1 -> one cycle after the 4th beat: out_data=0x44332211, out_count=4, out_last=0, single-cycle out_valid.
- Same beats with LSB_FIRST=0 -> out_data=0x11223344.
- Beats 0xAA,0xBB with in_last on 0xBB -> out_data=0x0000BBAA, out_count=2, out_last=1; the next word starts at segment 0.
- out_ready=0, stream 8 beats -> first word held stable, second word fills assembly, in_ready=0 after the 8th beat. Raise out_ready -> words taken in order 0x44332211 then 0x88776655, in_ready returns to 1.
- 12 back-to-back beats with out_ready=1 -> 3 words with no in_ready deassertion.
- Assert reset_n=0 after 2 beats of a word and while out_valid=1 -> out_valid=0 immediately. After release, 4 new beats produce a word containing no stale segments.
